// File: rtl/mult_ctrl_pkg.sv
// Shared types and key codes for the multiplier entry sequencer.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    ENTRY_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4
  } ctrl_state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage

// File: rtl/mult_entry_ctrl_if.sv
// Keypad-side and multiplier-side signals of the entry sequencer.
interface mult_entry_ctrl_if #(
  parameter int OP_W  = 10,
  parameter int CNT_W = 2
);
  logic             data_available;
  logic [3:0]       dato_i;
  logic [OP_W-1:0]  mult_a;
  logic [OP_W-1:0]  mult_b;
  logic             mult_start;
  logic             mult_done;
  logic             result_valid;
  logic             busy;
  logic             entry_sel;
  logic [CNT_W-1:0] digit_cnt;
  logic             timeout_o;

  modport master (
    input  data_available,
    input  dato_i,
    input  mult_done,
    output mult_a,
    output mult_b,
    output mult_start,
    output result_valid,
    output busy,
    output entry_sel,
    output digit_cnt,
    output timeout_o
  );

  modport slave (
    output data_available,
    output dato_i,
    output mult_done,
    input  mult_a,
    input  mult_b,
    input  mult_start,
    input  result_valid,
    input  busy,
    input  entry_sel,
    input  digit_cnt,
    input  timeout_o
  );

endinterface

// File: rtl/mult_entry_ctrl_dec_accum.sv
// Decimal-to-binary operand accumulator: val <= val*10 + digit, up to N_DIGITS digits.
module dec_accum #(
  parameter int OP_W     = 10,
  parameter int N_DIGITS = 3,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load_digit,
  input  logic [3:0]       digit,
  output logic [OP_W-1:0]  val,
  output logic [CNT_W-1:0] cnt
);

  logic [OP_W-1:0] times10;

  // Digit limit keeps val below 10^N_DIGITS, so the shift-add never overflows.
  assign times10 = (val << 3) + (val << 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      val <= '0;
      cnt <= '0;
    end else if (clr) begin
      if (load_digit) begin
        val <= OP_W'(digit);
        cnt <= CNT_W'(1);
      end else begin
        val <= '0;
        cnt <= '0;
      end
    end else if (load_digit && (cnt < CNT_W'(N_DIGITS))) begin
      val <= times10 + OP_W'(digit);
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_entry_ctrl.sv
// Keypad-to-multiplier entry sequencer. Optional idle auto-clear with macro ENTRY_TIMEOUT_EN.
//
// state   | meaning
// ENTRY_A | collecting digits of operand A
// ENTRY_B | collecting digits of operand B
// START   | one-cycle start pulse to the multiplier
// WAIT    | multiplier running, keys dropped
// SHOW    | result valid, operands held for display
module mult_entry_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 3,
  parameter int OP_W        = 10,
  parameter int TIMEOUT_CYC = 135000000
) (
  input logic              clk,
  input logic              rst,
  mult_entry_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(N_DIGITS + 1);

  ctrl_state_t      state_q, state_d;
  logic             da_q;
  logic             key_ev;
  logic             key_dig, key_ent, key_clr;
  logic             clr_a, clr_b, ld_a, ld_b;
  logic             tmo_hit;
  logic [OP_W-1:0]  val_a, val_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  assign key_ev  = bus.data_available & ~da_q;
  assign key_dig = key_ev & is_digit(bus.dato_i);
  assign key_ent = key_ev & (bus.dato_i == KEY_ENTER);
  assign key_clr = key_ev & (bus.dato_i == KEY_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ENTRY_A;
      da_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      da_q    <= bus.data_available;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    unique case (state_q)
      ENTRY_A: begin
        if (key_dig) begin
          ld_a = 1'b1;
        end else if (key_ent) begin
          state_d = ENTRY_B;
          clr_b   = 1'b1;
        end else if (key_clr) begin
          clr_a = 1'b1;
        end
      end
      ENTRY_B: begin
        if (key_dig) begin
          ld_b = 1'b1;
        end else if (key_ent) begin
          state_d = START;
        end else if (key_clr) begin
          clr_a   = 1'b1;
          clr_b   = 1'b1;
          state_d = ENTRY_A;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.mult_done) state_d = SHOW;
      end
      SHOW: begin
        // A digit here starts a fresh A with that digit already loaded.
        if (key_dig) begin
          clr_a   = 1'b1;
          ld_a    = 1'b1;
          clr_b   = 1'b1;
          state_d = ENTRY_A;
        end else if (key_clr) begin
          clr_a   = 1'b1;
          clr_b   = 1'b1;
          state_d = ENTRY_A;
        end else if (key_ent) begin
          state_d = START;
        end
      end
      default: state_d = ENTRY_A;
    endcase
    if (tmo_hit) begin
      clr_a   = 1'b1;
      clr_b   = 1'b1;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      state_d = ENTRY_A;
    end
  end

  dec_accum #(.OP_W(OP_W), .N_DIGITS(N_DIGITS), .CNT_W(CNT_W)) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_a),
    .load_digit (ld_a),
    .digit      (bus.dato_i),
    .val        (val_a),
    .cnt        (cnt_a)
  );

  dec_accum #(.OP_W(OP_W), .N_DIGITS(N_DIGITS), .CNT_W(CNT_W)) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_b),
    .load_digit (ld_b),
    .digit      (bus.dato_i),
    .val        (val_b),
    .cnt        (cnt_b)
  );

  assign bus.mult_a       = val_a;
  assign bus.mult_b       = val_b;
  assign bus.mult_start   = (state_q == START);
  assign bus.busy         = (state_q == START) || (state_q == WAIT);
  assign bus.result_valid = (state_q == SHOW);
  assign bus.entry_sel    = (state_q != ENTRY_A);
  assign bus.digit_cnt    = bus.entry_sel ? cnt_b : cnt_a;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] idle_q;
  logic             idle_run;
  logic             tmo_q;

  assign idle_run = ((state_q == ENTRY_A) && (cnt_a != '0)) || (state_q == ENTRY_B);
  // A key arriving in the expiry cycle takes precedence and reloads the timer.
  assign tmo_hit  = idle_run && (idle_q == '0) && !key_ev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_q <= TMO_W'(TIMEOUT_CYC - 1);
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (!idle_run || key_ev || tmo_hit || (state_d != state_q)) begin
        idle_q <= TMO_W'(TIMEOUT_CYC - 1);
      end else begin
        idle_q <= idle_q - TMO_W'(1);
      end
    end
  end

  assign bus.timeout_o = tmo_q;
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign bus.timeout_o      = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_mult_entry_ctrl.sv
// Self-checking bench for mult_entry_ctrl; operand pairs are scoreboarded against mult_start.
module tb_mult_entry_ctrl;

  localparam logic [3:0] K_ENT = 4'hA;
  localparam logic [3:0] K_CLR = 4'hB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int starts_seen = 0;
  int n_pushed = 0;
  logic prev_start = 1'b0;
  logic [19:0] exp_q[$];

  mult_entry_ctrl_if #(.OP_W(10), .CNT_W(2)) bus ();

  mult_entry_ctrl #(.N_DIGITS(3), .OP_W(10), .TIMEOUT_CYC(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every start pulse must carry the next queued operand pair.
  always @(negedge clk) begin
    if (bus.mult_start === 1'b1) begin
      starts_seen++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL start_unexpected: got a=%0d b=%0d, expected no start", bus.mult_a, bus.mult_b);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({bus.mult_a, bus.mult_b} !== e)
          $display("FAIL start_operands: got a=%0d b=%0d, expected a=%0d b=%0d",
                   bus.mult_a, bus.mult_b, e[19:10], e[9:0]);
        else n_pass++;
      end
      n_total++;
      if (prev_start === 1'b1) $display("FAIL start_width: got start high 2+ cycles, expected 1 cycle");
      else n_pass++;
    end
    prev_start = bus.mult_start;
  end

  task automatic press(input logic [3:0] key, input int hold);
    @(negedge clk);
    bus.dato_i = key;
    bus.data_available = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    bus.data_available = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    bus.mult_done = 1'b1;
    @(negedge clk);
    bus.mult_done = 1'b0;
  endtask

  task automatic push_exp(input int a, input int b);
    exp_q.push_back({10'(a), 10'(b)});
    n_pushed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.mult_a, bus.mult_b} !== 20'd0) $display("FAIL reset_operands: got a=%0d b=%0d, expected 0 0", bus.mult_a, bus.mult_b);
    else n_pass++;
    n_total++;
    if ({bus.mult_start, bus.result_valid, bus.busy, bus.entry_sel, bus.timeout_o} !== 5'b0)
      $display("FAIL reset_flags: got %b, expected 00000", {bus.mult_start, bus.result_valid, bus.busy, bus.entry_sel, bus.timeout_o});
    else n_pass++;
    n_total++;
    if (bus.digit_cnt !== 2'd0) $display("FAIL reset_digit_cnt: got %0d, expected 0", bus.digit_cnt);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    press(4'hE, 5);
    n_total++;
    if ({bus.mult_a, bus.digit_cnt} !== 12'd0) $display("FAIL ignored_key: got a=%0d cnt=%0d, expected 0 0", bus.mult_a, bus.digit_cnt);
    else n_pass++;
    press(4'd1, 5);
    press(4'd2, 5);
    n_total++;
    if (bus.mult_a !== 10'd12 || bus.digit_cnt !== 2'd2) $display("FAIL basic_a: got a=%0d cnt=%0d, expected 12 2", bus.mult_a, bus.digit_cnt);
    else n_pass++;
    press(K_ENT, 5);
    n_total++;
    if (bus.entry_sel !== 1'b1 || bus.digit_cnt !== 2'd0) $display("FAIL basic_enter_a: got sel=%b cnt=%0d, expected 1 0", bus.entry_sel, bus.digit_cnt);
    else n_pass++;
    press(4'd3, 5);
    press(4'd4, 5);
    n_total++;
    if (bus.mult_b !== 10'd34) $display("FAIL basic_b: got %0d, expected 34", bus.mult_b);
    else n_pass++;
    push_exp(12, 34);
    press(K_ENT, 5);
    n_total++;
    if (bus.busy !== 1'b1 || bus.mult_start !== 1'b0) $display("FAIL basic_wait: got busy=%b start=%b, expected 1 0", bus.busy, bus.mult_start);
    else n_pass++;
    n_total++;
    if (starts_seen !== 1) $display("FAIL basic_start_count: got %0d, expected 1", starts_seen);
    else n_pass++;
    pulse_done();
    n_total++;
    if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0 || bus.mult_a !== 10'd12 || bus.mult_b !== 10'd34)
      $display("FAIL basic_show: got rv=%b busy=%b a=%0d b=%0d, expected 1 0 12 34", bus.result_valid, bus.busy, bus.mult_a, bus.mult_b);
    else n_pass++;
    press(K_CLR, 5);
    n_total++;
    if ({bus.mult_a, bus.mult_b, bus.result_valid, bus.entry_sel} !== 22'd0)
      $display("FAIL show_clear: got a=%0d b=%0d rv=%b sel=%b, expected all 0", bus.mult_a, bus.mult_b, bus.result_valid, bus.entry_sel);
    else n_pass++;
  endtask

  task automatic test_saturate();
    press(4'd1, 5);
    press(4'd2, 5);
    press(4'd3, 5);
    press(4'd4, 5);
    n_total++;
    if (bus.mult_a !== 10'd123 || bus.digit_cnt !== 2'd3) $display("FAIL saturate: got a=%0d cnt=%0d, expected 123 3", bus.mult_a, bus.digit_cnt);
    else n_pass++;
    press(K_ENT, 5);
    n_total++;
    if (bus.entry_sel !== 1'b1 || bus.digit_cnt !== 2'd0 || bus.mult_a !== 10'd123)
      $display("FAIL saturate_enter: got sel=%b cnt=%0d a=%0d, expected 1 0 123", bus.entry_sel, bus.digit_cnt, bus.mult_a);
    else n_pass++;
  endtask

  task automatic test_clear_b();
    press(4'd5, 5);
    n_total++;
    if (bus.mult_b !== 10'd5) $display("FAIL clear_b_digit: got %0d, expected 5", bus.mult_b);
    else n_pass++;
    press(K_CLR, 5);
    n_total++;
    if ({bus.mult_a, bus.mult_b, bus.entry_sel, bus.digit_cnt, bus.busy} !== 24'd0)
      $display("FAIL clear_b: got a=%0d b=%0d sel=%b cnt=%0d busy=%b, expected all 0", bus.mult_a, bus.mult_b, bus.entry_sel, bus.digit_cnt, bus.busy);
    else n_pass++;
  endtask

  task automatic test_wait_drop();
    press(4'd2, 5);
    press(K_ENT, 5);
    press(4'd6, 5);
    push_exp(2, 6);
    press(K_ENT, 5);
    press(4'd7, 5);
    press(K_CLR, 5);
    n_total++;
    if (bus.mult_a !== 10'd2 || bus.mult_b !== 10'd6 || bus.busy !== 1'b1)
      $display("FAIL wait_keys_dropped: got a=%0d b=%0d busy=%b, expected 2 6 1", bus.mult_a, bus.mult_b, bus.busy);
    else n_pass++;
    @(negedge clk);
    bus.dato_i = 4'd5;
    bus.data_available = 1'b1;
    bus.mult_done = 1'b1;
    @(negedge clk);
    bus.mult_done = 1'b0;
    repeat (3) @(negedge clk);
    bus.data_available = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.result_valid !== 1'b1 || bus.mult_a !== 10'd2 || bus.mult_b !== 10'd6)
      $display("FAIL done_wins: got rv=%b a=%0d b=%0d, expected 1 2 6", bus.result_valid, bus.mult_a, bus.mult_b);
    else n_pass++;
    press(4'd9, 5);
    n_total++;
    if (bus.mult_a !== 10'd9 || bus.mult_b !== 10'd0 || bus.result_valid !== 1'b0 || bus.digit_cnt !== 2'd1 || bus.entry_sel !== 1'b0)
      $display("FAIL show_digit: got a=%0d b=%0d rv=%b cnt=%0d sel=%b, expected 9 0 0 1 0",
               bus.mult_a, bus.mult_b, bus.result_valid, bus.digit_cnt, bus.entry_sel);
    else n_pass++;
  endtask

  task automatic test_hold_long();
    int base;
    press(K_CLR, 5);
    press(4'd4, 50);
    n_total++;
    if (bus.mult_a !== 10'd4 || bus.digit_cnt !== 2'd1) $display("FAIL hold_once: got a=%0d cnt=%0d, expected 4 1", bus.mult_a, bus.digit_cnt);
    else n_pass++;
    press(K_ENT, 5);
    press(4'd3, 5);
    base = starts_seen;
    push_exp(4, 3);
    press(K_ENT, 5);
    pulse_done();
    push_exp(4, 3);
    press(K_ENT, 5);
    n_total++;
    if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) $display("FAIL rerun_state: got busy=%b rv=%b, expected 1 0", bus.busy, bus.result_valid);
    else n_pass++;
    n_total++;
    if (starts_seen !== base + 2) $display("FAIL rerun_count: got %0d, expected %0d", starts_seen, base + 2);
    else n_pass++;
    pulse_done();
    n_total++;
    if (bus.result_valid !== 1'b1) $display("FAIL rerun_show: got rv=%b, expected 1", bus.result_valid);
    else n_pass++;
    press(K_CLR, 5);
  endtask

  task automatic test_done_ignored();
    pulse_done();
    n_total++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.entry_sel !== 1'b0)
      $display("FAIL done_outside_wait: got rv=%b busy=%b sel=%b, expected 0 0 0", bus.result_valid, bus.busy, bus.entry_sel);
    else n_pass++;
    press(K_ENT, 5);
    n_total++;
    if (bus.entry_sel !== 1'b1 || bus.mult_a !== 10'd0) $display("FAIL empty_a: got sel=%b a=%0d, expected 1 0", bus.entry_sel, bus.mult_a);
    else n_pass++;
    press(K_CLR, 5);
  endtask

  task automatic test_reset_in_wait();
    press(4'd1, 5);
    press(K_ENT, 5);
    press(4'd1, 5);
    push_exp(1, 1);
    press(K_ENT, 5);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL rst_wait_pre: got busy=%b, expected 1", bus.busy);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.mult_a, bus.mult_b, bus.mult_start, bus.result_valid, bus.busy, bus.entry_sel, bus.digit_cnt, bus.timeout_o} !== 27'd0)
      $display("FAIL rst_in_wait: got a=%0d b=%0d busy=%b sel=%b, expected all 0", bus.mult_a, bus.mult_b, bus.busy, bus.entry_sel);
    else n_pass++;
    rst = 1'b1;
    pulse_done();
    n_total++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL done_after_rst: got rv=%b busy=%b, expected 0 0", bus.result_valid, bus.busy);
    else n_pass++;
  endtask

`ifdef ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    bit seen;
    seen = 1'b0;
    k = 0;
    press(4'd8, 5);
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.timeout_o === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (!seen || k < 90 || k > 100) $display("FAIL timeout_pulse: got seen=%0d after %0d cycles, expected seen=1 in 90..100", seen, k);
    else n_pass++;
    n_total++;
    if (bus.mult_a !== 10'd0 || bus.entry_sel !== 1'b0 || bus.digit_cnt !== 2'd0)
      $display("FAIL timeout_clear: got a=%0d sel=%b cnt=%0d, expected 0 0 0", bus.mult_a, bus.entry_sel, bus.digit_cnt);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.timeout_o !== 1'b0) $display("FAIL timeout_width: got %b, expected 0", bus.timeout_o);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.data_available = 1'b0;
    bus.dato_i = 4'd0;
    bus.mult_done = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_clear_b();
    test_wait_drop();
    test_hold_long();
    test_done_ignored();
    test_reset_in_wait();
`ifdef ENTRY_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (starts_seen !== n_pushed) $display("FAIL start_total: got %0d, expected %0d", starts_seen, n_pushed);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
